cpu_bus_arbiter: RTL and testbench

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

---
 rtl/cpu_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// Arbitrates the instruction and data caches onto a single SDRAM controller port.
// Icache gets 8-word wrapping bursts; dcache gets single-word reads or masked writes.
module cpu_bus_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        icache_request,
  input  logic [25:0] icache_address,
  output logic        icache_ack,
  output logic [31:0] icache_rdata,
  output logic        icache_valid,
  output logic        icache_complete,
  input  logic        dcache_request,
  input  logic        dcache_write,
  input  logic [25:0] dcache_address,
  input  logic [31:0] dcache_wdata,
  input  logic [3:0]  dcache_wmask,
  output logic        dcache_ack,
  output logic [31:0] dcache_rdata,
  output logic        dcache_valid,
  output logic        dcache_complete,
  output logic        sdram_request,
  output logic        sdram_write,
  output logic        sdram_burst,
  output logic [25:0] sdram_address,
  output logic [31:0] sdram_wdata,
  output logic [3:0]  sdram_wmask,
  input  logic        sdram_ack,
  input  logic        sdram_rvalid,
  input  logic [31:0] sdram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    IC_REQ,
    IC_DATA,
    DC_REQ,
    DC_DATA,
    DC_WDONE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        last_grant;
  logic [2:0]  word_count;
  logic        grant_ic;
  logic        grant_dc;

  assign icache_rdata = sdram_rdata;
  assign dcache_rdata = sdram_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // last_grant = 1 means dcache won most recently, so icache wins the next tie
  always_comb begin
    next_state      = state;
    grant_ic        = 1'b0;
    grant_dc        = 1'b0;
    icache_ack      = 1'b0;
    dcache_ack      = 1'b0;
    icache_valid    = 1'b0;
    dcache_valid    = 1'b0;
    icache_complete = 1'b0;
    dcache_complete = 1'b0;
    case (state)
      IDLE: begin
        if (icache_request && (!dcache_request || last_grant)) begin
          grant_ic   = 1'b1;
          next_state = IC_REQ;
        end else if (dcache_request) begin
          grant_dc   = 1'b1;
          next_state = DC_REQ;
        end
      end
      IC_REQ: begin
        icache_ack = sdram_ack;
        if (sdram_ack) begin
          next_state = IC_DATA;
        end
      end
      IC_DATA: begin
        icache_valid = sdram_rvalid;
        if (sdram_rvalid && word_count == 3'd7) begin
          icache_complete = 1'b1;
          next_state      = IDLE;
        end
      end
      DC_REQ: begin
        dcache_ack = sdram_ack;
        if (sdram_ack) begin
          next_state = sdram_write ? DC_WDONE : DC_DATA;
        end
      end
      DC_DATA: begin
        dcache_valid = sdram_rvalid;
        if (sdram_rvalid) begin
          dcache_complete = 1'b1;
          next_state      = IDLE;
        end
      end
      DC_WDONE: begin
        dcache_complete = 1'b1;
        next_state      = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured once at grant and held until the controller acks
  always_ff @(posedge clock) begin
    if (reset) begin
      sdram_request <= 1'b0;
      sdram_write   <= 1'b0;
      sdram_burst   <= 1'b0;
      sdram_address <= '0;
      sdram_wdata   <= '0;
      sdram_wmask   <= '0;
      last_grant    <= 1'b0;
      word_count    <= '0;
    end else begin
      if (grant_ic) begin
        sdram_request <= 1'b1;
        sdram_write   <= 1'b0;
        sdram_burst   <= 1'b1;
        sdram_address <= icache_address;
        sdram_wdata   <= '0;
        sdram_wmask   <= 4'hF;
        last_grant    <= 1'b0;
      end else if (grant_dc) begin
        sdram_request <= 1'b1;
        sdram_write   <= dcache_write;
        sdram_burst   <= 1'b0;
        sdram_address <= dcache_address;
        sdram_wdata   <= dcache_wdata;
        sdram_wmask   <= dcache_wmask;
        last_grant    <= 1'b1;
      end else if (sdram_request && sdram_ack) begin
        sdram_request <= 1'b0;
      end
      if (state == IC_REQ && sdram_ack) begin
        word_count <= '0;
      end else if (state == IC_DATA && sdram_rvalid) begin
        word_count <= word_count + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios plus randomized
// transactions checked against a grant-order and transaction-shape model.
module tb_cpu_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        icache_request;
  logic [25:0] icache_address;
  logic        icache_ack;
  logic [31:0] icache_rdata;
  logic        icache_valid;
  logic        icache_complete;
  logic        dcache_request;
  logic        dcache_write;
  logic [25:0] dcache_address;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_wmask;
  logic        dcache_ack;
  logic [31:0] dcache_rdata;
  logic        dcache_valid;
  logic        dcache_complete;
  logic        sdram_request;
  logic        sdram_write;
  logic        sdram_burst;
  logic [25:0] sdram_address;
  logic [31:0] sdram_wdata;
  logic [3:0]  sdram_wmask;
  logic        sdram_ack;
  logic        sdram_rvalid;
  logic [31:0] sdram_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  // Observations gathered while the bench plays the SDRAM controller
  int ic_ack_n, dc_ack_n, ic_val_n, dc_val_n, ic_comp_n, dc_comp_n;
  int ack_at, comp_at, comp_word, data_bad, field_chg, req_late;
  logic        lat_req, lat_write, lat_burst;
  logic [25:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;

  always #5 clock = ~clock;

  cpu_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .icache_request(icache_request), .icache_address(icache_address),
    .icache_ack(icache_ack), .icache_rdata(icache_rdata),
    .icache_valid(icache_valid), .icache_complete(icache_complete),
    .dcache_request(dcache_request), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_wmask(dcache_wmask), .dcache_ack(dcache_ack),
    .dcache_rdata(dcache_rdata), .dcache_valid(dcache_valid),
    .dcache_complete(dcache_complete),
    .sdram_request(sdram_request), .sdram_write(sdram_write),
    .sdram_burst(sdram_burst), .sdram_address(sdram_address),
    .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask),
    .sdram_ack(sdram_ack), .sdram_rvalid(sdram_rvalid), .sdram_rdata(sdram_rdata)
  );

  task automatic observe(input int cyc);
    #1;
    if (cyc == 0) begin
      lat_req = sdram_request; lat_write = sdram_write; lat_burst = sdram_burst;
      lat_addr = sdram_address; lat_wdata = sdram_wdata; lat_wmask = sdram_wmask;
    end else if (sdram_request && {sdram_write, sdram_burst, sdram_address, sdram_wdata, sdram_wmask}
                 !== {lat_write, lat_burst, lat_addr, lat_wdata, lat_wmask}) begin
      field_chg++;
    end
    if (icache_ack) begin ic_ack_n++; ack_at = cyc; end
    if (dcache_ack) begin dc_ack_n++; ack_at = cyc; end
    if (ack_at >= 0 && cyc > ack_at && sdram_request) req_late++;
    if (icache_valid) begin ic_val_n++; if (icache_rdata !== sdram_rdata) data_bad++; end
    if (dcache_valid) begin dc_val_n++; if (dcache_rdata !== sdram_rdata) data_bad++; end
    if (icache_complete) begin ic_comp_n++; comp_at = cyc; comp_word = ic_val_n; end
    if (dcache_complete) begin dc_comp_n++; comp_at = cyc; comp_word = dc_val_n; end
    @(negedge clock);
  endtask

  // Plays the SDRAM controller for one transaction; starts on the first cycle sdram_request is high
  task automatic serve(input int ack_delay, input int words, input int max_gap,
                       input bit spurious, input int extra);
    int cyc = 0;
    ic_ack_n = 0; dc_ack_n = 0; ic_val_n = 0; dc_val_n = 0; ic_comp_n = 0; dc_comp_n = 0;
    ack_at = -1; comp_at = -1; comp_word = -1; data_bad = 0; field_chg = 0; req_late = 0;
    for (int d = 0; d < ack_delay; d++) begin
      sdram_ack = 1'b0; sdram_rvalid = spurious && (d == 0); sdram_rdata = $urandom;
      observe(cyc); cyc++;
    end
    sdram_ack = 1'b1; sdram_rvalid = 1'b0;
    observe(cyc); cyc++;
    sdram_ack = 1'b0;
    if (words == 0) begin observe(cyc); cyc++; end
    for (int w = 0; w < words; w++) begin
      repeat ($urandom_range(max_gap, 0)) begin sdram_rvalid = 1'b0; observe(cyc); cyc++; end
      sdram_rvalid = 1'b1; sdram_rdata = $urandom;
      observe(cyc); cyc++;
    end
    sdram_rvalid = 1'b0;
    repeat (extra) begin observe(cyc); cyc++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; icache_request = 1'b1; dcache_request = 1'b1;
    sdram_ack = 1'b1; sdram_rvalid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    tests_run++;
    if ({sdram_request, sdram_write, sdram_burst, sdram_address, sdram_wdata, sdram_wmask,
         icache_ack, dcache_ack, icache_valid, dcache_valid, icache_complete, dcache_complete} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got req=%0b addr=%0h wmask=%0h acks=%0b%0b valids=%0b%0b, required all 0",
               sdram_request, sdram_address, sdram_wmask, icache_ack, dcache_ack, icache_valid, dcache_valid);
    end
    icache_request = 1'b0; dcache_request = 1'b0; sdram_ack = 1'b0; sdram_rvalid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_arbitration();
    bit exp_ic = 1'b0;
    reset = 1'b1; icache_request = 1'b1; dcache_request = 1'b1;
    icache_address = 26'h0ABCDE0; dcache_address = 26'h0001234;
    dcache_write = 1'b0; dcache_wdata = 32'h0; dcache_wmask = 4'hF;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    tests_run++;
    if (sdram_request !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL arb_latency: sdram_request got %0b required 0", sdram_request);
    end
    @(negedge clock);
    for (int t = 0; t < 4; t++) begin
      serve(2, exp_ic ? 8 : 1, 1, 1'b0, 0);
      tests_run++;
      if ({lat_req, lat_burst, lat_addr} !== {1'b1, exp_ic, exp_ic ? 26'h0ABCDE0 : 26'h0001234}) begin
        tests_failed++;
        $display("[TB] FAIL arb_order[%0d]: got req=%0b burst=%0b addr=%0h required burst=%0b",
                 t, lat_req, lat_burst, lat_addr, exp_ic);
      end
      tests_run++;
      if ({ic_comp_n, dc_comp_n} !== (exp_ic ? {32'd1, 32'd0} : {32'd0, 32'd1})) begin
        tests_failed++;
        $display("[TB] FAIL arb_complete[%0d]: got ic=%0d dc=%0d required winner only", t, ic_comp_n, dc_comp_n);
      end
      #1;
      tests_run++;
      if (sdram_request !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL arb_idle_gap[%0d]: sdram_request got %0b required 0", t, sdram_request);
      end
      @(negedge clock);
      exp_ic = !exp_ic;
    end
    icache_request = 1'b0; dcache_request = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_icache_burst();
    icache_request = 1'b1; icache_address = 26'h0012340;
    #1;
    @(negedge clock);
    serve(3, 8, 2, 1'b0, 0);
    icache_request = 1'b0;
    tests_run++;
    if ({lat_req, lat_burst, lat_write, lat_addr, lat_wmask} !== {1'b1, 1'b1, 1'b0, 26'h0012340, 4'hF}) begin
      tests_failed++;
      $display("[TB] FAIL ic_fields: got req=%0b burst=%0b write=%0b addr=%0h wmask=%0h required 1 1 0 12340 f",
               lat_req, lat_burst, lat_write, lat_addr, lat_wmask);
    end
    tests_run++;
    if ({ic_ack_n, ack_at, ic_val_n, ic_comp_n, comp_word} !== {32'd1, 32'd3, 32'd8, 32'd1, 32'd8}) begin
      tests_failed++;
      $display("[TB] FAIL ic_burst: got acks=%0d ack_at=%0d valids=%0d completes=%0d at_word=%0d required 1 3 8 1 8",
               ic_ack_n, ack_at, ic_val_n, ic_comp_n, comp_word);
    end
    tests_run++;
    if ({dc_ack_n, dc_val_n, dc_comp_n, data_bad, field_chg, req_late} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL ic_side_effects: got dc_ack=%0d dc_val=%0d dc_comp=%0d data_bad=%0d field_chg=%0d req_late=%0d required 0",
               dc_ack_n, dc_val_n, dc_comp_n, data_bad, field_chg, req_late);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_dcache_write();
    dcache_request = 1'b1; dcache_write = 1'b1; dcache_address = 26'h0000100;
    dcache_wdata = 32'hDEADBEEF; dcache_wmask = 4'b0011;
    @(negedge clock);
    dcache_request = 1'b0;
    serve(1, 0, 0, 1'b0, 2);
    tests_run++;
    if ({lat_req, lat_burst, lat_write, lat_addr, lat_wdata, lat_wmask}
        !== {1'b1, 1'b0, 1'b1, 26'h0000100, 32'hDEADBEEF, 4'b0011}) begin
      tests_failed++;
      $display("[TB] FAIL dw_fields: got burst=%0b write=%0b addr=%0h wdata=%0h wmask=%0h required 0 1 100 deadbeef 3",
               lat_burst, lat_write, lat_addr, lat_wdata, lat_wmask);
    end
    tests_run++;
    if ({dc_ack_n, dc_comp_n, dc_val_n, comp_at - ack_at} !== {32'd1, 32'd1, 32'd0, 32'd1}) begin
      tests_failed++;
      $display("[TB] FAIL dw_complete: got acks=%0d completes=%0d valids=%0d delay=%0d required 1 1 0 1",
               dc_ack_n, dc_comp_n, dc_val_n, comp_at - ack_at);
    end
    dcache_write = 1'b0;
  endtask

  task automatic test_dcache_read_spurious();
    dcache_request = 1'b1; dcache_write = 1'b0; dcache_address = 26'($urandom);
    dcache_wmask = 4'($urandom);
    @(negedge clock);
    dcache_request = 1'b0;
    serve(2, 1, 2, 1'b1, 2);
    tests_run++;
    if ({lat_write, lat_burst, lat_addr, lat_wmask} !== {1'b0, 1'b0, dcache_address, dcache_wmask}) begin
      tests_failed++;
      $display("[TB] FAIL dr_fields: got write=%0b burst=%0b addr=%0h wmask=%0h required 0 0 %0h %0h",
               lat_write, lat_burst, lat_addr, lat_wmask, dcache_address, dcache_wmask);
    end
    tests_run++;
    if ({dc_ack_n, dc_val_n, dc_comp_n, comp_word, data_bad} !== {32'd1, 32'd1, 32'd1, 32'd1, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL dr_spurious: got acks=%0d valids=%0d completes=%0d at_word=%0d data_bad=%0d required 1 1 1 1 0",
               dc_ack_n, dc_val_n, dc_comp_n, comp_word, data_bad);
    end
  endtask

  task automatic test_reset_mid_burst();
    int seen = 0;
    icache_request = 1'b1; icache_address = 26'h0004000;
    @(negedge clock);
    icache_request = 1'b0; sdram_ack = 1'b1;
    @(negedge clock);
    sdram_ack = 1'b0;
    for (int w = 0; w < 4; w++) begin
      sdram_rvalid = 1'b1; sdram_rdata = $urandom;
      #1;
      if (icache_valid) seen++;
      @(negedge clock);
    end
    tests_run++;
    if (seen !== 4) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_words: got %0d valids required 4", seen);
    end
    sdram_rvalid = 1'b0; reset = 1'b1;
    @(negedge clock);
    sdram_rvalid = 1'b1;
    #1;
    tests_run++;
    if ({sdram_request, sdram_write, sdram_burst, sdram_address, sdram_wdata, sdram_wmask,
         icache_ack, icache_valid, icache_complete, dcache_valid, dcache_complete} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_outputs: got req=%0b burst=%0b addr=%0h valid=%0b complete=%0b required all 0",
               sdram_request, sdram_burst, sdram_address, icache_valid, icache_complete);
    end
    @(negedge clock);
    reset = 1'b0; seen = 0;
    repeat (4) begin
      sdram_rvalid = 1'b1;
      #1;
      if (icache_valid || icache_complete) seen++;
      @(negedge clock);
    end
    sdram_rvalid = 1'b0;
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_stale: got %0d stale valid/complete cycles required 0", seen);
    end
    dcache_request = 1'b1; dcache_write = 1'b0; dcache_address = 26'h0000040;
    @(negedge clock);
    dcache_request = 1'b0;
    serve(0, 1, 0, 1'b0, 1);
    tests_run++;
    if ({lat_req, lat_burst, lat_addr, dc_comp_n, ic_comp_n} !== {1'b1, 1'b0, 26'h0000040, 32'd1, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_regrant: got req=%0b burst=%0b addr=%0h dc_comp=%0d ic_comp=%0d required 1 0 40 1 0",
               lat_req, lat_burst, lat_addr, dc_comp_n, ic_comp_n);
    end
  endtask

  task automatic test_request_drop();
    icache_request = 1'b1; icache_address = 26'h3FFFFE0;
    @(negedge clock);
    icache_request = 1'b0;
    serve(2, 8, 1, 1'b1, 3);
    tests_run++;
    if ({lat_req, lat_addr, ic_val_n, ic_comp_n, comp_word, req_late}
        !== {1'b1, 26'h3FFFFE0, 32'd8, 32'd1, 32'd8, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL drop_complete: got req=%0b addr=%0h valids=%0d completes=%0d at_word=%0d req_late=%0d required 1 3ffffe0 8 1 8 0",
               lat_req, lat_addr, ic_val_n, ic_comp_n, comp_word, req_late);
    end
  endtask

  // Model: a lone requester wins; on a tie the client not granted last wins
  task automatic test_random();
    bit model_last_ic = 1'b1;
    bit ic, dc, win_ic, dwr;
    int delay, words;
    logic [25:0] ia, da;
    logic [31:0] wd;
    logic [3:0]  wm;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int it = 0; it < 30; it++) begin
      ic = 1'($urandom); dc = 1'($urandom);
      if (!ic && !dc) ic = 1'b1;
      ia = 26'($urandom); da = 26'($urandom); wd = $urandom; wm = 4'($urandom); dwr = 1'($urandom);
      icache_request = ic; dcache_request = dc; icache_address = ia;
      dcache_address = da; dcache_write = dwr; dcache_wdata = wd; dcache_wmask = wm;
      #1;
      tests_run++;
      if (sdram_request !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rand_latency[%0d]: sdram_request got %0b required 0", it, sdram_request);
      end
      @(negedge clock);
      icache_request = 1'b0; dcache_request = 1'b0;
      win_ic = ic && (!dc || !model_last_ic);
      model_last_ic = win_ic;
      words = win_ic ? 8 : (dwr ? 0 : 1);
      delay = $urandom_range(3, 0);
      serve(delay, words, 2, (delay > 0) && 1'($urandom), 1);
      tests_run++;
      if (win_ic ? ({lat_req, lat_burst, lat_write, lat_addr, lat_wmask} !== {1'b1, 1'b1, 1'b0, ia, 4'hF})
                 : ({lat_req, lat_burst, lat_write, lat_addr, lat_wmask, lat_wdata} !== {1'b1, 1'b0, dwr, da, wm, wd})) begin
        tests_failed++;
        $display("[TB] FAIL rand_fields[%0d]: got burst=%0b write=%0b addr=%0h wmask=%0h required icache=%0b addr=%0h",
                 it, lat_burst, lat_write, lat_addr, lat_wmask, win_ic, win_ic ? ia : da);
      end
      tests_run++;
      if ({ic_ack_n, dc_ack_n, ack_at} !== {32'(win_ic), 32'(!win_ic), delay}) begin
        tests_failed++;
        $display("[TB] FAIL rand_ack[%0d]: got ic=%0d dc=%0d at=%0d required icache=%0b at=%0d",
                 it, ic_ack_n, dc_ack_n, ack_at, win_ic, delay);
      end
      tests_run++;
      if (win_ic ? ({ic_val_n, dc_val_n, ic_comp_n, dc_comp_n, comp_word} !== {32'd8, 32'd0, 32'd1, 32'd0, 32'd8})
                 : ({ic_val_n, dc_val_n, ic_comp_n, dc_comp_n} !== {32'd0, words, 32'd0, 32'd1})) begin
        tests_failed++;
        $display("[TB] FAIL rand_data[%0d]: got ic_val=%0d dc_val=%0d ic_comp=%0d dc_comp=%0d required icache=%0b words=%0d",
                 it, ic_val_n, dc_val_n, ic_comp_n, dc_comp_n, win_ic, words);
      end
      tests_run++;
      if ({data_bad, field_chg, req_late, (words == 0) ? comp_at - ack_at : 32'd1} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin
        tests_failed++;
        $display("[TB] FAIL rand_integrity[%0d]: got data_bad=%0d field_chg=%0d req_late=%0d wdone_delay=%0d required 0 0 0 1",
                 it, data_bad, field_chg, req_late, comp_at - ack_at);
      end
    end
  endtask

  initial begin
    reset = 1'b1; icache_request = 1'b0; icache_address = '0;
    dcache_request = 1'b0; dcache_write = 1'b0; dcache_address = '0;
    dcache_wdata = '0; dcache_wmask = '0;
    sdram_ack = 1'b0; sdram_rvalid = 1'b0; sdram_rdata = '0;
    @(negedge clock);
    test_reset();
    test_arbitration();
    test_icache_burst();
    test_dcache_write();
    test_dcache_read_spurious();
    test_reset_mid_burst();
    test_request_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
